// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_unit
// Description : HI/LO register file and sequencer for an external shift-add
//               multiplier. Accepts MULT/MADDU from EX. For each multiply it
//               clears the multiplier, then holds the operands and the
//               function code for the full iteration window. It then
//               captures the 64-bit product into HI/LO: MULT overwrites and
//               MADDU accumulates. It also serves MFHI/MFLO/MTHI/MTLO, and
//               stalls the front of the pipeline while a multiply is in
//               flight.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   op_valid     EX presents a HI/LO-class instruction this cycle
//   funct        instruction funct field
//   rs_data      operand A; also the MTHI/MTLO source
//   rt_data      operand B
//   mf_data      MFHI/MFLO read data (combinational)
//   stall        freeze IF/ID/EX this cycle (combinational)
//   busy         multiply in flight (registered)
//   mul_reset    reset to the multiplier
//   mul_signal   function code to the multiplier (zero outside RUN)
//   mul_dataA    multiplicand
//   mul_dataB    multiplier operand
//   mul_product  multiplier result
//   hi, lo       HI and LO registers
//
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit #(
    parameter int         MUL_ITER = 33,
    parameter logic [5:0] F_MULT   = 6'b011001,
    parameter logic [5:0] F_MADDU  = 6'b000001,
    parameter logic [5:0] F_MFHI   = 6'b010000,
    parameter logic [5:0] F_MTHI   = 6'b010001,
    parameter logic [5:0] F_MFLO   = 6'b010010,
    parameter logic [5:0] F_MTLO   = 6'b010011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy,
    output logic        mul_reset,
    output logic [5:0]  mul_signal,
    output logic [31:0] mul_dataA,
    output logic [31:0] mul_dataB,
    input  logic [63:0] mul_product,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int            c_CNT_W    = $clog2(MUL_ITER);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [5:0]         r_op_latch;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;

    logic               w_is_mul;
    logic               w_is_hilo;
    logic [63:0]        w_acc_sum;

    // Funct decode
    always_comb begin
        w_is_mul  = (funct == F_MULT) || (funct == F_MADDU);
        w_is_hilo = w_is_mul ||
                    (funct == F_MFHI) || (funct == F_MFLO) ||
                    (funct == F_MTHI) || (funct == F_MTLO);
    end

    // MADDU accumulation wraps at 64 bits; the carry out is dropped.
    assign w_acc_sum = {hi, lo} + mul_product;

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (op_valid && w_is_mul) w_next = S_CLR;
            S_CLR:  w_next = S_RUN;
            S_RUN:  if (r_cnt == c_CNT_LAST) w_next = S_CAP;
            S_CAP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, operand latches and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op_latch <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        if (w_is_mul) begin
                            r_op_latch <= funct;
                            r_op_a     <= rs_data;
                            r_op_b     <= rt_data;
                            busy       <= 1'b1;
                        end else if (funct == F_MTHI) begin
                            hi <= rs_data;
                        end else if (funct == F_MTLO) begin
                            lo <= rs_data;
                        end
                    end
                end
                S_CLR: begin
                    r_cnt <= '0;
                end
                S_RUN: begin
                    if (r_cnt != c_CNT_LAST) r_cnt <= r_cnt + 1'b1;
                end
                S_CAP: begin
                    // op_latch only ever holds MULT or MADDU here.
                    if (r_op_latch == F_MADDU) begin
                        {hi, lo} <= w_acc_sum;
                    end else begin
                        {hi, lo} <= mul_product;
                    end
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Combinational outputs
    always_comb begin
        stall      = op_valid && w_is_hilo && (busy || (r_state != S_IDLE));
        mul_reset  = reset || (r_state == S_CLR);
        mul_signal = (r_state == S_RUN) ? r_op_latch : 6'd0;
        mul_dataA  = r_op_a;
        mul_dataB  = r_op_b;
        if (funct == F_MFHI) begin
            mf_data = hi;
        end else if (funct == F_MFLO) begin
            mf_data = lo;
        end else begin
            mf_data = 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_unit
// Description : Self-checking bench for hilo_unit. It includes a
//               cycle-counting multiplier stub. The stub returns the true
//               product only after exactly 33 cycles of a steady function
//               code and steady operands. The bench also keeps a
//               transaction-level model of HI/LO and of the 35-cycle
//               multiply window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;

    localparam logic [5:0] F_MULT  = 6'b011001;
    localparam logic [5:0] F_MADDU = 6'b000001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam int         WINDOW  = 35;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data;
    logic [31:0] mf_data;
    logic        stall, busy, mul_reset;
    logic [5:0]  mul_signal;
    logic [31:0] mul_dataA, mul_dataB;
    logic [63:0] mul_product;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    hilo_unit dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .mf_data(mf_data),
        .stall(stall), .busy(busy), .mul_reset(mul_reset),
        .mul_signal(mul_signal), .mul_dataA(mul_dataA), .mul_dataB(mul_dataB),
        .mul_product(mul_product), .hi(hi), .lo(lo)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (f == F_MULT) return sa * sb;
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic bit is_hilo(input logic [5:0] f);
        return f == F_MULT || f == F_MADDU || f == F_MFHI ||
               f == F_MFLO || f == F_MTHI || f == F_MTLO;
    endfunction

    // ---------------- multiplier stub ----------------
    int          m_cnt;
    bit          m_bad;
    logic [5:0]  m_sig;
    logic [31:0] m_a, m_b;

    always @(posedge clk) begin
        if (mul_reset) begin
            m_cnt <= 0;
            m_bad <= 1'b0;
        end else if (mul_signal != 6'd0) begin
            if (m_cnt == 0) begin
                m_sig <= mul_signal;
                m_a   <= mul_dataA;
                m_b   <= mul_dataB;
            end else if (mul_signal != m_sig || mul_dataA != m_a || mul_dataB != m_b) begin
                m_bad <= 1'b1;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    assign mul_product = (m_cnt == 33 && !m_bad) ? prod(m_sig, m_a, m_b)
                                                 : 64'hBAD0_BAD0_BAD0_BAD0;

    // mul_signal run-length monitor (runs cut by reset are not judged)
    int run_len = 0;
    bit run_rst = 1'b0;
    always @(negedge clk) begin
        #2;
        if (mul_signal !== 6'd0 && mul_signal !== 6'bx) begin
            run_len++;
            if (reset) run_rst = 1'b1;
        end else begin
            if (run_len > 0 && !run_rst && !reset) check("mul_signal_len", run_len, 33);
            run_len = 0;
            run_rst = 1'b0;
        end
    end

    // ---------------- transaction-level model ----------------
    int          rem = 0;          // cycles left in the multiply window
    logic [31:0] rhi = 0, rlo = 0;
    logic [5:0]  pf;
    logic [31:0] pa, pb;
    logic [31:0] last_mf;

    // Called at a negedge: drive, check against model, advance, next negedge.
    task automatic step(input logic v, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic r, output logic s);
        logic        e_stall;
        logic [31:0] e_mf;
        reset = r; op_valid = v; funct = f; rs_data = a; rt_data = b;
        #1;
        e_stall = v && is_hilo(f) && (rem > 0);
        e_mf    = (f == F_MFHI) ? rhi : (f == F_MFLO) ? rlo : 32'd0;
        check("stall", stall, e_stall);
        check("busy", busy, rem > 0);
        check("hi", hi, rhi);
        check("lo", lo, rlo);
        check("mul_reset", mul_reset, r || rem == WINDOW);
        check("mul_signal", mul_signal, (rem >= 2 && rem <= WINDOW - 1) ? pf : 6'd0);
        if (v && !e_stall) check("mf_data", mf_data, e_mf);
        s       = stall;
        last_mf = mf_data;
        if (r) begin
            rem = 0; rhi = 0; rlo = 0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                if (pf == F_MADDU) {rhi, rlo} = {rhi, rlo} + prod(pf, pa, pb);
                else               {rhi, rlo} = prod(pf, pa, pb);
            end
        end else if (v) begin
            if (f == F_MTHI) rhi = a;
            else if (f == F_MTLO) rlo = a;
            else if (f == F_MULT || f == F_MADDU) begin
                rem = WINDOW; pf = f; pa = a; pb = b;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an instruction and hold it while stalled; n = stalled cycles.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int n);
        logic s;
        n = 0;
        step(1'b1, f, a, b, 1'b0, s);
        while (s) begin
            n++;
            if (n > 100) begin
                check("issue_timeout", 1, 0);
                break;
            end
            step(1'b1, f, a, b, 1'b0, s);
        end
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++)
            step(1'b0, 6'($urandom_range(0, 63)), $urandom, $urandom, 1'b0, s);
    endtask

    typedef struct {
        logic        v;
        logic [5:0]  f;
        logic [31:0] a;
        logic        e_stall;
        logic [31:0] e_mf;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } tv_t;

    tv_t tv[9];

    initial begin
        int   n;
        logic s;

        tv[0] = '{1'b0, F_MFHI,    32'h0,        1'b0, 32'h0,        32'h0,        32'h0};
        tv[1] = '{1'b1, F_MTHI,    32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
        tv[2] = '{1'b1, F_MTLO,    32'h12345678, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tv[3] = '{1'b1, F_MFHI,    32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678};
        tv[4] = '{1'b1, F_MFLO,    32'h0,        1'b0, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        tv[5] = '{1'b1, 6'b100000, 32'h55555555, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tv[6] = '{1'b0, F_MTHI,    32'hFFFFFFFF, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tv[7] = '{1'b1, F_MTLO,    32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
        tv[8] = '{1'b1, F_MFLO,    32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 32'h0};

        // Reset with a MULT presented: must not stall or be accepted
        reset = 1'b1; op_valid = 1'b1; funct = F_MULT; rs_data = 32'd9; rt_data = 32'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_mul_reset", mul_reset, 1'b1);
        check("rst_mul_signal", mul_signal, 6'd0);
        step(1'b1, F_MULT, 32'd9, 32'd9, 1'b1, s);

        // Single-cycle ops from the table
        for (int i = 0; i < 9; i++) begin
            reset = 1'b0; op_valid = tv[i].v; funct = tv[i].f;
            rs_data = tv[i].a; rt_data = $urandom;
            #1;
            check($sformatf("tv%0d_stall", i), stall, tv[i].e_stall);
            check($sformatf("tv%0d_mf", i), mf_data, tv[i].e_mf);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tv%0d_hi", i), hi, tv[i].e_hi);
            check($sformatf("tv%0d_lo", i), lo, tv[i].e_lo);
        end
        rhi = tv[8].e_hi;
        rlo = tv[8].e_lo;

        // Basic MULT 3*5
        issue(F_MULT, 32'd3, 32'd5, n);
        check("mult_busy_rise", busy, 1'b1);
        idle(WINDOW);
        check("mult_hi", hi, 32'h0);
        check("mult_lo", lo, 32'h0000000F);
        check("mult_busy_fall", busy, 1'b0);

        // MADDU accumulate on top of 15
        issue(F_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        idle(WINDOW);
        check("maddu_acc", {hi, lo}, 64'hFFFFFFFE_00000010);

        // MADDU wrap
        issue(F_MTHI, 32'hFFFFFFFF, 32'h0, n);
        issue(F_MTLO, 32'hFFFFFFFF, 32'h0, n);
        issue(F_MADDU, 32'd1, 32'd1, n);
        idle(WINDOW);
        check("maddu_wrap", {hi, lo}, 64'h0);

        // Interlock: MFLO right after MULT 7*6
        issue(F_MULT, 32'd7, 32'd6, n);
        issue(F_MFLO, 32'h0, 32'h0, n);
        check("interlock_stalls", n, WINDOW);
        check("interlock_mf", last_mf, 32'h0000002A);

        // Back-to-back MULTs
        issue(F_MULT, 32'd2, 32'd2, n);
        issue(F_MULT, 32'd3, 32'd3, n);
        check("b2b_stalls", n, WINDOW);
        idle(WINDOW);
        check("b2b_lo", lo, 32'd9);
        check("b2b_hi", hi, 32'd0);

        // Reset during RUN at cnt=10
        issue(F_MTHI, 32'h1234, 32'h0, n);
        issue(F_MULT, 32'h10000, 32'h10000, n);
        idle(11);
        step(1'b0, F_MFHI, 32'h0, 32'h0, 1'b1, s);
        reset = 1'b0; op_valid = 1'b1; funct = F_MFHI;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_mfhi", mf_data, 32'h0);
        step(1'b1, F_MFHI, 32'h0, 32'h0, 1'b0, s);

        // Randomised traffic against the model
        for (int k = 0; k < 150; k++) begin
            int          sel;
            logic [5:0]  f;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                step(1'b0, F_MULT, $urandom, $urandom, 1'b1, s);
            end else if (sel <= 3) begin
                issue(F_MULT, $urandom, $urandom, n);
            end else if (sel <= 5) begin
                issue(F_MADDU, $urandom, $urandom, n);
            end else if (sel <= 7) begin
                issue(F_MTHI, $urandom, $urandom, n);
            end else if (sel <= 9) begin
                issue(F_MTLO, $urandom, $urandom, n);
            end else if (sel <= 11) begin
                issue(F_MFHI, $urandom, $urandom, n);
            end else if (sel <= 13) begin
                issue(F_MFLO, $urandom, $urandom, n);
            end else if (sel <= 15) begin
                f = 6'($urandom_range(0, 63));
                while (is_hilo(f)) f = 6'($urandom_range(0, 63));
                issue(f, $urandom, $urandom, n);
                check("other_no_stall", n, 0);
            end else begin
                idle($urandom_range(1, 4));
            end
        end
        idle(WINDOW + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sequencer and HI/LO register file sitting between the EX stage and the shift-add multiplier.
- Accepts MULT/MADDU from EX, clears the multiplier, drives its operands and function code for the full iteration window, then captures the 64-bit product into HI/LO. MULT overwrites; MADDU accumulates.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall while a multiply is in flight.

Parameters:
- MUL_ITER, 33, cycles the multiplier must see a valid function code: 1 load cycle plus 32 shift cycles.
- F_MULT, 6'b011001, funct code for MULT.
- F_MADDU, 6'b000001, funct code for MADDU.
- F_MFHI, 6'b010000, funct code for MFHI.
- F_MTHI, 6'b010001, funct code for MTHI.
- F_MFLO, 6'b010010, funct code for MFLO.
- F_MTLO, 6'b010011, funct code for MTLO.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  EX presents a HI/LO-class instruction this cycle.
- funct  in  6  instruction funct field.
- rs_data  in  32  operand A; also the MTHI/MTLO source.
- rt_data  in  32  operand B.
- mf_data  out  32  MFHI/MFLO read data (combinational).
- stall  out  1  freeze IF/ID/EX this cycle (combinational).
- busy  out  1  multiply in flight (registered).
- mul_reset  out  1  reset to the multiplier.
- mul_signal  out  6  function code to the multiplier.
- mul_dataA  out  32  multiplicand.
- mul_dataB  out  32  multiplier operand.
- mul_product  in  64  multiplier result.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, cnt=0, op_latch=0, opA=0, opB=0.
  - mul_reset = reset OR (state==CLR).
  - mul_signal=0 whenever state!=RUN.
- States: IDLE, CLR, RUN, CAP.
- IDLE:
  - op_valid with funct F_MULT/F_MADDU: latch funct into op_latch, rs_data into opA, rt_data into opB; go to CLR; busy<=1.
  - F_MTHI: hi<=rs_data. F_MTLO: lo<=rs_data. Both complete in 1 cycle.
  - F_MFHI/F_MFLO: mf_data=hi/lo the same cycle; no stall.
  - Any other funct with op_valid: ignored; no stall; mf_data=0.
- CLR: one cycle with mul_reset=1 so the multiplier's accumulator and counter are zero. cnt<=0; go to RUN.
- RUN:
  - mul_signal=op_latch, mul_dataA=opA, mul_dataB=opB, held constant.
  - cnt increments every cycle; when cnt==MUL_ITER-1, go to CAP.
  - mul_signal is therefore valid for exactly MUL_ITER cycles.
- CAP:
  - F_MULT: {hi,lo}<=mul_product.
  - F_MADDU: {hi,lo}<={hi,lo}+mul_product, unsigned 64-bit add, carry out of bit 63 discarded (wrap).
  - busy<=0; go to IDLE.
- mul_dataA/mul_dataB drive opA/opB in all states; they are don't-care outside RUN.
- Latency: accept edge to HI/LO update = 1 (CLR) + MUL_ITER (RUN) + 1 (CAP) = 35 cycles.
  - busy is high from the cycle after acceptance through the CAP cycle inclusive.
  - The first instruction may issue in the cycle after CAP.
- stall = op_valid AND (busy OR state!=IDLE) AND funct is one of the six HI/LO codes.
  - EX holds the instruction while stalled; it is re-evaluated each cycle.
  - Unrecognised funct never stalls.
- mf_data:
  - Source is hi for F_MFHI, lo for F_MFLO, else 0.
  - Valid only when stall=0.
  - In the cycle after CAP, reads return the freshly written HI/LO, not the pre-multiply values.
- Simultaneous events: only one op is accepted per cycle. A second MULT/MADDU arriving in CAP stalls that cycle and is accepted the next cycle in IDLE.
- Reset mid-operation: any state goes to IDLE in one cycle. hi/lo are cleared and the in-flight product is discarded. mul_reset is asserted during reset.
- Operand capture: operand changes on rs_data/rt_data after acceptance have no effect.

Test Plan:
- Basic MULT: after reset, MULT rs=3, rt=5 -> busy rises the next cycle; at cycle 35 hi=0x00000000, lo=0x0000000F; busy=0.
- MADDU accumulate: MADDU rs=0xFFFFFFFF, rt=0xFFFFFFFF on top of the previous result -> after 35 cycles {hi,lo}=0xFFFFFFFE_00000010.
- MADDU wrap: MTHI 0xFFFFFFFF, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=0, lo=0 (carry dropped).
- Interlock: MFLO issued 1 cycle after a MULT 7*6 -> stall=1 for every cycle until CAP; mf_data=0x0000002A on the first unstalled cycle.
- Back-to-back: MULT 2*2 immediately followed by MULT 3*3 -> the second stalls through CAP, is accepted the next cycle, and final lo=9. Monitor checks mul_reset pulses once per op and mul_signal is held exactly 33 cycles.
- Reset mid-op: MULT 0x10000*0x10000, then reset at RUN cnt=10 -> the next cycle state=IDLE, hi=lo=0, busy=0, stall=0. A subsequent MFHI returns 0.
